// File: rtl/dino_jump_phys.sv
// rtl/dino_jump_phys.sv - dino vertical jump physics, tick divider and obstacle collision detector
module dino_jump_phys #(
    parameter int TICK_DIV = 500000,
    parameter int HW       = 8,
    parameter int XW       = 10,
    parameter int V0       = 8,
    parameter int DINO_X   = 32,
    parameter int DINO_W   = 16,
    parameter int OBST_W   = 12,
    parameter int OBST_H   = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          jump,
    input  logic [XW-1:0] obst_x,
    input  logic          obst_valid,
    output logic [HW-1:0] dino_y,
    output logic          airborne,
    output logic          crash,
    output logic          tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [XW:0] DINO_RIGHT = (XW+1)'(DINO_X + DINO_W);
    localparam logic [XW:0] DINO_LEFT  = (XW+1)'(DINO_X);
    localparam logic [XW:0] OBST_WIDTH = (XW+1)'(OBST_W);
    localparam logic [HW:0] OBST_TOP   = (HW+1)'(OBST_H);

    typedef enum logic [1:0] {
        DEAD = 2'd0,
        IDLE = 2'd1,
        RISE = 2'd2,
        FALL = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [HW-1:0] v, v_nx, y_nx;
    logic          jump_q, jump_rise, hit, crash_nx;
    logic [XW:0]   ox;
    logic [HW:0]   rise_sum, fall_step;

    assign tick      = (cnt == CW'(TICK_DIV - 1));
    assign jump_rise = jump & ~jump_q;
    assign airborne  = (state == RISE) || (state == FALL);

    // Widened by one bit so obst_x + OBST_W cannot wrap near the right edge
    assign ox  = {1'b0, obst_x};
    assign hit = obst_valid && (ox < DINO_RIGHT) && ((ox + OBST_WIDTH) > DINO_LEFT)
                 && ({1'b0, dino_y} < OBST_TOP);

    assign rise_sum  = {1'b0, dino_y} + {1'b0, v};
    assign fall_step = {1'b0, v} + (HW+1)'(1);

    always_comb begin
        state_nx = state;
        y_nx     = dino_y;
        v_nx     = v;
        crash_nx = 1'b0;
        case (state)
            DEAD: begin
                if (jump_rise) begin
                    y_nx     = '0;
                    v_nx     = HW'(V0);
                    state_nx = RISE;
                end
            end
            IDLE: begin
                if (hit) begin
                    crash_nx = 1'b1;
                    state_nx = DEAD;
                end else if (jump_rise) begin
                    v_nx     = HW'(V0);
                    state_nx = RISE;
                end
            end
            RISE: begin
                if (hit) begin
                    crash_nx = 1'b1;
                    state_nx = DEAD;
                end else if (tick) begin
                    y_nx = rise_sum[HW] ? '1 : rise_sum[HW-1:0];
                    if (v == HW'(1)) begin
                        v_nx     = '0;
                        state_nx = FALL;
                    end else begin
                        v_nx = v - HW'(1);
                    end
                end
            end
            FALL: begin
                if (hit) begin
                    crash_nx = 1'b1;
                    state_nx = DEAD;
                end else if (tick) begin
                    v_nx = v + HW'(1);
                    if ({1'b0, dino_y} <= fall_step) begin
                        y_nx     = '0;
                        state_nx = IDLE;
                    end else begin
                        y_nx = dino_y - fall_step[HW-1:0];
                    end
                end
            end
            default: state_nx = DEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        // jump_q follows jump even in reset so a level held across reset is not a new event
        jump_q <= jump;
        if (!rst_n) begin
            state  <= DEAD;
            dino_y <= '0;
            v      <= '0;
            crash  <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            dino_y <= y_nx;
            v      <= v_nx;
            crash  <= crash_nx;
            cnt    <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_dino_jump_phys.sv
// tb/tb_dino_jump_phys.sv - self-checking bench for dino_jump_phys
module tb_dino_jump_phys;

    localparam int TICK_DIV = 4;
    localparam int HW       = 8;
    localparam int XW       = 10;
    localparam int V0       = 4;
    localparam int DINO_X   = 32;
    localparam int DINO_W   = 16;
    localparam int OBST_W   = 12;
    localparam int OBST_H   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          jump = 1'b0;
    logic [XW-1:0] obst_x = '0;
    logic          obst_valid = 1'b0;
    logic [HW-1:0] dino_y;
    logic          airborne;
    logic          crash;
    logic          tick;

    dino_jump_phys #(
        .TICK_DIV(TICK_DIV), .HW(HW), .XW(XW), .V0(V0),
        .DINO_X(DINO_X), .DINO_W(DINO_W), .OBST_W(OBST_W), .OBST_H(OBST_H)
    ) dut (
        .clk(clk), .rst_n(rst_n), .jump(jump), .obst_x(obst_x), .obst_valid(obst_valid),
        .dino_y(dino_y), .airborne(airborne), .crash(crash), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] x;
        logic          valid;
        logic          exp_crash;
        string         name;
    } geo_vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [HW-1:0] exp_q[$];
    logic [HW-1:0] arc_tab[8];
    geo_vec_t      geo[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_jump(input string name);
        jump = 1'b1;
        step();
        check(name, {31'd0, airborne}, 32'd1);
    endtask

    // Scoreboard-driven arc: expected heights queued at the jump, popped on each DUT tick update
    task automatic run_arc(input int stop_after, input int glitch_after, input bit dodge,
                           output int crash_seen);
        int   pops;
        int   guard;
        bit   t;
        bit   glitch_pending;
        logic [HW-1:0] e;
        pops = 0;
        guard = 0;
        crash_seen = 0;
        glitch_pending = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(arc_tab[i]);
        while (exp_q.size() > 0 && pops != stop_after && guard < 200) begin
            if (glitch_pending) begin
                jump = 1'b1;
                glitch_pending = 0;
            end
            if (dodge) begin
                obst_x = XW'(DINO_X);
                obst_valid = (dino_y >= 9);
            end
            t = tick;
            step();
            guard++;
            if (crash) crash_seen++;
            if (t) begin
                e = exp_q.pop_front();
                check("arc_y", {24'd0, dino_y}, {24'd0, e});
                pops++;
                if (pops == glitch_after) begin
                    jump = 1'b0;
                    glitch_pending = 1;
                end
            end
        end
        obst_valid = 1'b0;
        if (guard >= 200) check("arc_timeout", 32'd1, 32'd0);
        if (stop_after < 0) check("arc_lands_idle", {31'd0, airborne}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs;
        int hits;
        int g;
        arc_tab = '{8'd4, 8'd7, 8'd9, 8'd10, 8'd9, 8'd7, 8'd4, 8'd0};
        geo[0] = '{10'd32,   1'b1, 1'b1, "geo_x_eq_dino_x"};
        geo[1] = '{10'd21,   1'b1, 1'b1, "geo_left_touch"};
        geo[2] = '{10'd20,   1'b1, 1'b0, "geo_left_miss"};
        geo[3] = '{10'd47,   1'b1, 1'b1, "geo_right_touch"};
        geo[4] = '{10'd48,   1'b1, 1'b0, "geo_right_miss"};
        geo[5] = '{10'd32,   1'b0, 1'b0, "geo_invalid"};
        geo[6] = '{10'd1023, 1'b1, 1'b0, "geo_no_wrap"};
        geo[7] = '{10'd0,    1'b1, 1'b0, "geo_x_zero"};

        // Reset state and free-running tick
        rst_n = 1'b0;
        step();
        step();
        check("rst_y", {24'd0, dino_y}, 32'd0);
        check("rst_airborne", {31'd0, airborne}, 32'd0);
        check("rst_crash", {31'd0, crash}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        rst_n = 1'b1;
        step(); check("tick_c1", {31'd0, tick}, 32'd0);
        step(); check("tick_c2", {31'd0, tick}, 32'd0);
        step(); check("tick_c3", {31'd0, tick}, 32'd1);
        step(); check("tick_c4", {31'd0, tick}, 32'd0);

        // First jump from DEAD: airborne one clock after the edge, full arc
        start_jump("dead_jump_airborne");
        run_arc(-1, 0, 1'b0, cs);

        // Jump edge coincident with a tick: first height update waits for the next tick
        jump = 1'b0;
        step();
        g = 0;
        while (!tick && g < 10) begin step(); g++; end
        check("tick_found", {31'd0, tick}, 32'd1);
        start_jump("tick_jump_airborne");
        run_arc(-1, 0, 1'b0, cs);

        // Held level gives a single arc
        hits = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (airborne) hits++;
        end
        check("held_no_rearm", hits, 32'd0);

        // Rising edge mid-FALL is ignored
        jump = 1'b0;
        step();
        start_jump("glitch_jump_airborne");
        run_arc(-1, 5, 1'b0, cs);

        // Obstacle only present while dino is above it
        jump = 1'b0;
        step();
        start_jump("dodge_jump_airborne");
        run_arc(-1, 0, 1'b1, cs);
        check("dodge_no_crash", cs, 32'd0);

        // Hitbox geometry, each vector applied from IDLE
        foreach (geo[i]) begin
            jump = 1'b0;
            step();
            start_jump("geo_jump_airborne");
            run_arc(-1, 0, 1'b0, cs);
            obst_x = geo[i].x;
            obst_valid = geo[i].valid;
            step();
            check(geo[i].name, {31'd0, crash}, {31'd0, geo[i].exp_crash});
            step();
            check("crash_one_cycle", {31'd0, crash}, 32'd0);
            if (geo[i].exp_crash) begin
                check("ground_hit_y", {24'd0, dino_y}, 32'd0);
                check("ground_hit_air", {31'd0, airborne}, 32'd0);
            end
            obst_valid = 1'b0;
        end

        // Mid-air hit freezes height and ends in DEAD
        jump = 1'b0;
        step();
        start_jump("air_jump_airborne");
        run_arc(1, 0, 1'b0, cs);
        obst_x = XW'(DINO_X);
        obst_valid = 1'b1;
        step();
        check("air_hit_crash", {31'd0, crash}, 32'd1);
        check("air_hit_y", {24'd0, dino_y}, 32'd4);
        check("air_hit_air", {31'd0, airborne}, 32'd0);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (crash) hits++;
        end
        check("dead_ignores_hit", hits, 32'd0);
        check("dead_y_frozen", {24'd0, dino_y}, 32'd4);
        obst_valid = 1'b0;
        jump = 1'b0;
        step();
        start_jump("restart_airborne");
        check("restart_y", {24'd0, dino_y}, 32'd0);
        run_arc(-1, 0, 1'b0, cs);

        // Hit and jump edge together in IDLE: hit wins and the edge is consumed
        jump = 1'b0;
        step();
        obst_x = XW'(DINO_X);
        obst_valid = 1'b1;
        jump = 1'b1;
        step();
        check("hitjump_crash", {31'd0, crash}, 32'd1);
        check("hitjump_air", {31'd0, airborne}, 32'd0);
        obst_valid = 1'b0;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (airborne) hits++;
        end
        check("hitjump_consumed", hits, 32'd0);

        // Reset mid-jump at y=9, with jump still held
        jump = 1'b0;
        step();
        start_jump("rstmid_jump_airborne");
        run_arc(3, 0, 1'b0, cs);
        check("rstmid_pre_y", {24'd0, dino_y}, 32'd9);
        rst_n = 1'b0;
        step();
        check("rstmid_y", {24'd0, dino_y}, 32'd0);
        check("rstmid_air", {31'd0, airborne}, 32'd0);
        check("rstmid_crash", {31'd0, crash}, 32'd0);
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (airborne) hits++;
        end
        check("rstmid_no_arc", hits, 32'd0);
        jump = 1'b0;
        step();
        start_jump("rstmid_rearm");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
